alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: decodes an ALU_Op/funct request, completes simple
// operations in one cycle, and runs multiply (shift-add) and unsigned divide
// (restoring) iteratively, one bit per cycle. The result is held until the
// consumer accepts it.
module alu_op_sequencer #(
    parameter int WIDTH   = 32,
    parameter int FUNCT_W = 6,
    parameter int OP_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    alu_op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [3:0]         alu_control,
    output logic               illegal,
    output logic               div_by_zero,
    output logic               busy
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int CNT_W = SHW + 1;

    localparam logic [3:0] CTRL_NONE  = 4'b0000;
    localparam logic [3:0] CTRL_ADD0  = 4'b0001;
    localparam logic [3:0] CTRL_SUB0  = 4'b0010;
    localparam logic [3:0] CTRL_ADD   = 4'b0011;
    localparam logic [3:0] CTRL_SUB   = 4'b0100;
    localparam logic [3:0] CTRL_MUL   = 4'b0101;
    localparam logic [3:0] CTRL_DIV   = 4'b0110;
    localparam logic [3:0] CTRL_OR    = 4'b0111;
    localparam logic [3:0] CTRL_AND   = 4'b1000;
    localparam logic [3:0] CTRL_XOR   = 4'b1001;
    localparam logic [3:0] CTRL_SLL   = 4'b1010;
    localparam logic [3:0] CTRL_SRL   = 4'b1011;
    localparam logic [3:0] CTRL_SLT   = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;

    // The decoded control code fully captures alu_op/funct, so it is what
    // gets registered at acceptance.
    logic [3:0]         r_aluCtrl;
    logic               r_illegal;
    logic               r_divByZero;
    logic [WIDTH-1:0]   r_result;
    logic [CNT_W-1:0]   r_count;

    // Shared iteration registers.
    // mul: r_acc = partial product, r_opA = shifted multiplicand, r_opB = multiplier
    // div: r_acc = remainder,       r_opA = dividend/quotient,    r_opB = divisor
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_opA;
    logic [WIDTH-1:0]   r_opB;

    logic [3:0]         w_decCtrl;
    logic               w_decIllegal;
    logic               w_isMul;
    logic               w_isDiv;
    logic               w_divZero;
    logic               w_multiCycle;
    logic               w_accept;
    logic               w_execLast;
    logic               w_lt;
    logic [WIDTH-1:0]   w_quickResult;

    logic [WIDTH-1:0]   w_mulAccNext;
    logic [WIDTH:0]     w_divShift;
    logic               w_divFits;
    logic [WIDTH-1:0]   w_divRemNext;
    logic [WIDTH-1:0]   w_divQuotNext;

    // Decode the incoming ALU_Op/funct pair into a 4-bit control code.
    always_comb begin
        w_decCtrl    = CTRL_NONE;
        w_decIllegal = 1'b0;
        if (alu_op == OP_W'(0)) begin
            w_decCtrl = CTRL_ADD0;
        end else if (alu_op == OP_W'(1)) begin
            w_decCtrl = CTRL_SUB0;
        end else if (alu_op == OP_W'(2)) begin
            w_decCtrl = CTRL_SLT;
        end else begin
            case (funct)
                FUNCT_W'(0): w_decCtrl = CTRL_ADD;
                FUNCT_W'(1): w_decCtrl = CTRL_SUB;
                FUNCT_W'(2): w_decCtrl = CTRL_MUL;
                FUNCT_W'(3): w_decCtrl = CTRL_DIV;
                FUNCT_W'(4): w_decCtrl = CTRL_OR;
                FUNCT_W'(5): w_decCtrl = CTRL_AND;
                FUNCT_W'(6): w_decCtrl = CTRL_XOR;
                FUNCT_W'(7): w_decCtrl = CTRL_SLL;
                FUNCT_W'(8): w_decCtrl = CTRL_SRL;
                FUNCT_W'(9): w_decCtrl = CTRL_SLT;
                default: begin
                    w_decCtrl    = CTRL_NONE;
                    w_decIllegal = 1'b1;
                end
            endcase
        end
    end

    // Compute single-cycle results straight from the request operands.
    always_comb begin
        w_isMul      = (w_decCtrl == CTRL_MUL);
        w_isDiv      = (w_decCtrl == CTRL_DIV);
        w_divZero    = w_isDiv && (b == '0);
        w_multiCycle = (w_isMul || w_isDiv) && !w_divZero;
        w_lt         = ($signed(a) < $signed(b));
        w_quickResult = '0;
        case (w_decCtrl)
            CTRL_ADD0, CTRL_ADD: w_quickResult = a + b;
            CTRL_SUB0, CTRL_SUB: w_quickResult = a - b;
            CTRL_OR:             w_quickResult = a | b;
            CTRL_AND:            w_quickResult = a & b;
            CTRL_XOR:            w_quickResult = a ^ b;
            CTRL_SLL:            w_quickResult = a << b[SHW-1:0];
            CTRL_SRL:            w_quickResult = a >> b[SHW-1:0];
            CTRL_SLT:            w_quickResult = {{(WIDTH-1){1'b0}}, w_lt};
            CTRL_DIV:            w_quickResult = '1;
            default:             w_quickResult = '0;
        endcase
    end

    // One step of shift-add multiply and of restoring division.
    always_comb begin
        w_mulAccNext  = r_acc + (r_opB[0] ? r_opA : '0);
        w_divShift    = {r_acc, r_opA[WIDTH-1]};
        w_divFits     = (w_divShift >= {1'b0, r_opB});
        w_divRemNext  = w_divFits ? (w_divShift[WIDTH-1:0] - r_opB)
                                  : w_divShift[WIDTH-1:0];
        w_divQuotNext = {r_opA[WIDTH-2:0], w_divFits};
    end

    // Next-state and handshake outputs; reset blocks acceptance.
    always_comb begin
        w_stateNext = r_state;
        in_ready    = (r_state == IDLE) && !rst;
        out_valid   = (r_state == DONE);
        busy        = (r_state != IDLE);
        w_accept    = in_ready && in_valid;
        w_execLast  = (r_state == EXEC) && (r_count == '0);
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_stateNext = w_multiCycle ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (w_execLast) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Datapath: capture the request, iterate mul/div, and hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aluCtrl   <= CTRL_NONE;
            r_illegal   <= 1'b0;
            r_divByZero <= 1'b0;
            r_result    <= '0;
            r_count     <= '0;
            r_acc       <= '0;
            r_opA       <= '0;
            r_opB       <= '0;
        end else if (w_accept) begin
            r_aluCtrl   <= w_decCtrl;
            r_illegal   <= w_decIllegal;
            r_divByZero <= w_divZero;
            r_acc       <= '0;
            r_opA       <= a;
            r_opB       <= b;
            if (w_multiCycle) begin
                r_count  <= CNT_W'(WIDTH - 1);
                r_result <= '0;
            end else begin
                r_count  <= '0;
                r_result <= w_quickResult;
            end
        end else if (r_state == EXEC) begin
            if (!w_execLast) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (r_aluCtrl == CTRL_DIV) begin
                r_acc <= w_divRemNext;
                r_opA <= w_divQuotNext;
                if (w_execLast) begin
                    r_result <= w_divQuotNext;
                end
            end else begin
                r_acc <= w_mulAccNext;
                r_opA <= r_opA << 1;
                r_opB <= r_opB >> 1;
                if (w_execLast) begin
                    r_result <= w_mulAccNext;
                end
            end
        end
    end

    // Registered status is presented directly.
    always_comb begin
        result      = r_result;
        alu_control = r_aluCtrl;
        illegal     = r_illegal;
        div_by_zero = r_divByZero;
    end

endmodule
